// File: rtl/gpio_cmd_ctrl_v5_if.sv
// rtl/gpio_cmd_ctrl_v5_if.sv - PS-side bus bundle for the GPIO command decoder
interface gpio_cmd_ctrl_v5_if #(
  parameter int NCH   = 2,
  parameter int LVL_W = 14,
  parameter int CNT_W = 16
);
  logic [31:0]            SELECT_in;
  logic [31:0]            DATA_in0;
  logic [CNT_W-1:0]       DATAcnt_in0;
  logic                   full;
  logic [31:0]            GPIO_out;
  logic                   _RESET_out;
  logic                   DATAread_out0;
  logic                   WRITE_EN_out;
  logic [NCH*2*LVL_W-1:0] TRGLEVEL_out;
  logic [3:0]             ADC_clk_div;
  logic [3:0]             MCS_clk_div;
  logic [11:0]            shape_conf;

  modport master (
    output SELECT_in, DATA_in0, DATAcnt_in0, full,
    input  GPIO_out, _RESET_out, DATAread_out0, WRITE_EN_out,
           TRGLEVEL_out, ADC_clk_div, MCS_clk_div, shape_conf
  );

  modport slave (
    input  SELECT_in, DATA_in0, DATAcnt_in0, full,
    output GPIO_out, _RESET_out, DATAread_out0, WRITE_EN_out,
           TRGLEVEL_out, ADC_clk_div, MCS_clk_div, shape_conf
  );
endinterface

// File: rtl/gpio_cmd_ctrl_v5.sv
// rtl/gpio_cmd_ctrl_v5.sv - PS-GPIO command decoder with run FSM, sticky flags and seq counter
module gpio_cmd_ctrl_v5 #(
  parameter int NCH     = 2,
  parameter int LVL_W   = 14,
  parameter int CNT_W   = 16,
  parameter int RST_LEN = 4
) (
  input  logic              sys_clk,
  input  logic              _RESET_in,
  gpio_cmd_ctrl_v5_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STOP = 2'b10} state_t;

  localparam int RW = $clog2(RST_LEN + 1);
  localparam int TW = NCH * 2 * LVL_W;

  state_t            state, state_d;
  logic [RW-1:0]     rst_cnt, rst_cnt_d;
  logic              rst_low;
  logic [11:0]       sel_q, armed, edges;
  logic [3:0]        ch_idx;
  logic [LVL_W-1:0]  lvl_data;
  logic              start_ok, stop_ok, conflict, idx_bad, lvl_req, lvl_ok;
  logic              cnt_zero, rd_ok, err_ev, uf_ev, accepted;
  logic              rd_q, err_q, uf_q;
  logic [7:0]        seq_q;
  logic [TW-1:0]     trg_q;
  logic [3:0]        adc_q, mcs_q;
  logic [11:0]       shape_q;
  logic [15:0]       cnt_ext;
  logic [31:0]       status;
  logic              unused_bits;

  // A bit must be sampled low since reset before its rise counts, so a level
  // held across reset release never fires.
  assign edges    = bus.SELECT_in[11:0] & ~sel_q & armed;
  assign ch_idx   = bus.SELECT_in[15:12];
  assign lvl_data = bus.SELECT_in[16 +: LVL_W];
  assign cnt_zero = (bus.DATAcnt_in0 == '0);

  assign conflict = edges[0] & edges[3];
  assign start_ok = edges[0] & ~edges[3];
  assign stop_ok  = edges[3] & ~edges[0];
  assign idx_bad  = ({28'd0, ch_idx} >= 32'(NCH));
  assign lvl_req  = edges[4] | edges[5];
  assign lvl_ok   = lvl_req & ~idx_bad;
  assign rd_ok    = edges[2] & ~cnt_zero;
  assign uf_ev    = edges[2] & cnt_zero;
  assign err_ev   = conflict | (lvl_req & idx_bad);
  assign accepted = start_ok | stop_ok | rd_ok | lvl_ok | edges[8] | edges[9] | edges[10];

  always_comb begin
    state_d   = state;
    rst_cnt_d = rst_cnt;
    if (rst_cnt != '0) rst_cnt_d = rst_cnt - RW'(1);
    if (start_ok) begin
      state_d   = RUN;
      rst_cnt_d = RW'(RST_LEN);
    end else if (stop_ok) begin
      state_d = STOP;
    end
  end

  always_ff @(posedge sys_clk or negedge _RESET_in) begin
    if (!_RESET_in) begin
      state   <= IDLE;
      rst_cnt <= '0;
      rst_low <= 1'b0;
      sel_q   <= '0;
      armed   <= '0;
    end else begin
      state   <= state_d;
      rst_cnt <= rst_cnt_d;
      rst_low <= (rst_cnt_d != '0);
      sel_q   <= bus.SELECT_in[11:0];
      armed   <= armed | ~bus.SELECT_in[11:0];
    end
  end

  always_ff @(posedge sys_clk or negedge _RESET_in) begin
    if (!_RESET_in) begin
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      uf_q    <= 1'b0;
      seq_q   <= '0;
      trg_q   <= '0;
      adc_q   <= '0;
      mcs_q   <= '0;
      shape_q <= '0;
    end else begin
      rd_q  <= rd_ok;
      // Clear is overridden by an error raised in the same cycle.
      err_q <= err_ev | (err_q & ~edges[10]);
      uf_q  <= uf_ev | (uf_q & ~edges[10]);
      if (accepted) seq_q <= seq_q + 8'd1;
      if (lvl_ok) begin
        for (int k = 0; k < NCH; k++) begin
          if (ch_idx == 4'(k)) begin
            if (edges[4]) trg_q[(2*k+1)*LVL_W +: LVL_W] <= lvl_data;
            if (edges[5]) trg_q[(2*k)*LVL_W +: LVL_W]   <= lvl_data;
          end
        end
      end
      if (edges[8]) begin
        adc_q <= bus.SELECT_in[19:16];
        mcs_q <= bus.SELECT_in[23:20];
      end
      if (edges[9]) shape_q <= bus.SELECT_in[27:16];
    end
  end

  always_comb begin
    cnt_ext              = '0;
    cnt_ext[CNT_W-1:0]   = bus.DATAcnt_in0;
  end

  assign status = {seq_q, 3'b000, uf_q, err_q, state, bus.full, cnt_ext};

  assign bus.GPIO_out      = bus.SELECT_in[1] ? status : bus.DATA_in0;
  assign bus._RESET_out    = ~rst_low;
  assign bus.DATAread_out0 = rd_q;
  assign bus.WRITE_EN_out  = (state == RUN);
  assign bus.TRGLEVEL_out  = trg_q;
  assign bus.ADC_clk_div   = adc_q;
  assign bus.MCS_clk_div   = mcs_q;
  assign bus.shape_conf    = shape_q;

  assign unused_bits = ^{bus.SELECT_in[31:28], edges[11], edges[7:6], edges[1]};
endmodule

// File: tb/tb_gpio_cmd_ctrl_v5.sv
// tb/tb_gpio_cmd_ctrl_v5.sv - directed bench with behavioural model for gpio_cmd_ctrl_v5
module tb_gpio_cmd_ctrl_v5;
  localparam int NCH = 2, LVL_W = 14, CNT_W = 16, RST_LEN = 4;
  localparam int TW = NCH * 2 * LVL_W;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  gpio_cmd_ctrl_v5_if #(.NCH(NCH), .LVL_W(LVL_W), .CNT_W(CNT_W)) bus ();

  gpio_cmd_ctrl_v5 #(.NCH(NCH), .LVL_W(LVL_W), .CNT_W(CNT_W), .RST_LEN(RST_LEN)) dut (
    .sys_clk   (clk),
    ._RESET_in (rst_n),
    .bus       (bus)
  );

  int n_vec = 0;
  int n_miss = 0;
  int n_low = 0;
  int n_rd = 0;
  bit chk_on = 1'b0;

  // Model: each SELECT bit remembers its last sampled level (2 = unknown after reset).
  int               m_prev[12];
  int               m_state;
  int               m_rst_left;
  int               m_seq;
  bit               m_rd, m_err, m_uf;
  logic [LVL_W-1:0] m_h[NCH];
  logic [LVL_W-1:0] m_l[NCH];
  logic [3:0]       m_adc, m_mcs;
  logic [11:0]      m_shape;
  bit [11:0]        rise;
  bit               acc, e_ev, u_ev;
  int               idx;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 12; b++) m_prev[b] = 2;
      m_state = 0; m_rst_left = 0; m_seq = 0;
      m_rd = 0; m_err = 0; m_uf = 0;
      for (int k = 0; k < NCH; k++) begin m_h[k] = '0; m_l[k] = '0; end
      m_adc = '0; m_mcs = '0; m_shape = '0;
    end else begin
      for (int b = 0; b < 12; b++) rise[b] = (bus.SELECT_in[b] == 1'b1) && (m_prev[b] == 0);
      acc = 0; e_ev = 0; u_ev = 0; m_rd = 0;
      if (m_rst_left > 0) m_rst_left--;
      if (rise[0] && rise[3]) e_ev = 1;
      else if (rise[0]) begin m_state = 1; m_rst_left = RST_LEN; acc = 1; end
      else if (rise[3]) begin m_state = 2; acc = 1; end
      if (rise[2]) begin
        if (bus.DATAcnt_in0 != 0) begin m_rd = 1; acc = 1; end
        else u_ev = 1;
      end
      if (rise[4] || rise[5]) begin
        idx = int'(bus.SELECT_in[15:12]);
        if (idx >= NCH) e_ev = 1;
        else begin
          if (rise[4]) m_h[idx] = bus.SELECT_in[16 +: LVL_W];
          if (rise[5]) m_l[idx] = bus.SELECT_in[16 +: LVL_W];
          acc = 1;
        end
      end
      if (rise[8]) begin m_adc = bus.SELECT_in[19:16]; m_mcs = bus.SELECT_in[23:20]; acc = 1; end
      if (rise[9]) begin m_shape = bus.SELECT_in[27:16]; acc = 1; end
      if (rise[10]) begin m_err = 0; m_uf = 0; acc = 1; end
      if (e_ev) m_err = 1;
      if (u_ev) m_uf = 1;
      if (acc) m_seq = (m_seq + 1) % 256;
      for (int b = 0; b < 12; b++) m_prev[b] = bus.SELECT_in[b] ? 1 : 0;
    end
  end

  function automatic logic [31:0] m_status();
    return 32'(bus.DATAcnt_in0) + (32'(bus.full) << 16) + (32'(m_state) << 17)
         + (32'(m_err) << 19) + (32'(m_uf) << 20) + (32'(m_seq) << 24);
  endfunction

  function automatic logic [TW-1:0] m_trg();
    logic [TW-1:0] t = '0;
    for (int k = 0; k < NCH; k++) begin
      t[(2*k+1)*LVL_W +: LVL_W] = m_h[k];
      t[(2*k)*LVL_W +: LVL_W]   = m_l[k];
    end
    return t;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("gpio_out", 64'(bus.GPIO_out), 64'(bus.SELECT_in[1] ? m_status() : bus.DATA_in0));
      check("reset_out", 64'(bus._RESET_out), 64'(m_rst_left == 0));
      check("dataread", 64'(bus.DATAread_out0), 64'(m_rd));
      check("write_en", 64'(bus.WRITE_EN_out), 64'(m_state == 1));
      check("trglevel", 64'(bus.TRGLEVEL_out), 64'(m_trg()));
      check("divs", 64'({bus.MCS_clk_div, bus.ADC_clk_div}), 64'({m_mcs, m_adc}));
      check("shape", 64'(bus.shape_conf), 64'(m_shape));
    end
  end

  task automatic step(input logic [31:0] s);
    @(posedge clk);
    #2 bus.SELECT_in = s;
    @(negedge clk);
    if (!bus._RESET_out) n_low++;
    if (bus.DATAread_out0) n_rd++;
  endtask

  task automatic hold(input logic [31:0] s, input int n);
    for (int i = 0; i < n; i++) step(s);
  endtask

  task automatic set_data(input logic [CNT_W-1:0] c, input logic f);
    @(posedge clk);
    #1;
    bus.DATAcnt_in0 = c;
    bus.full = f;
  endtask

  initial begin
    logic [TW-1:0] trg_exp;
    bus.SELECT_in = 32'h2;
    bus.DATA_in0 = 32'hDEAD_BEEF;
    bus.DATAcnt_in0 = 16'd5;
    bus.full = 1'b0;
    #1 rst_n = 1'b0;
    chk_on = 1'b1;
    hold(32'h2, 2);
    check("reset_status", 64'(bus.GPIO_out), 64'h0000_0005);
    @(posedge clk);
    #2 rst_n = 1'b1;
    hold(32'h2, 2);

    n_low = 0;
    hold(32'h3, 10);
    check("start_low_cycles", 64'(n_low), 64'd4);
    check("start_status", 64'(bus.GPIO_out), 64'h0102_0005);
    check("start_wen", 64'(bus.WRITE_EN_out), 64'd1);

    hold(32'h2, 2);
    n_rd = 0;
    hold(32'h6, 20);
    hold(32'h2, 2);
    check("read_pulses", 64'(n_rd), 64'd1);
    set_data(16'd0, 1'b0);
    n_rd = 0;
    hold(32'h6, 2);
    hold(32'h2, 2);
    check("underflow_pulses", 64'(n_rd), 64'd0);
    check("underflow_status", 64'(bus.GPIO_out), 64'h0212_0000);

    hold(32'h1ABC_1012, 2);
    trg_exp = '0;
    trg_exp[3*LVL_W +: LVL_W] = 14'h1ABC;
    check("lvl_ch1_h", 64'(bus.TRGLEVEL_out), 64'(trg_exp));
    hold(32'h2, 1);
    hold(32'h0555_2022, 2);
    check("lvl_bad_idx_trg", 64'(bus.TRGLEVEL_out), 64'(trg_exp));
    check("lvl_bad_idx_status", 64'(bus.GPIO_out), 64'h031A_0000);
    hold(32'h2, 1);
    hold(32'h0123_0032, 2);
    trg_exp[1*LVL_W +: LVL_W] = 14'h0123;
    trg_exp[0 +: LVL_W] = 14'h0123;
    check("lvl_ch0_both", 64'(bus.TRGLEVEL_out), 64'(trg_exp));
    check("lvl_ch0_status", 64'(bus.GPIO_out), 64'h041A_0000);

    hold(32'h2, 1);
    hold(32'h402, 2);
    check("clear_status", 64'(bus.GPIO_out), 64'h0502_0000);
    hold(32'h2, 1);
    n_low = 0;
    hold(32'hB, 2);
    check("conflict_status", 64'(bus.GPIO_out), 64'h050A_0000);
    check("conflict_no_pulse", 64'(n_low), 64'd0);
    hold(32'h2, 1);
    hold(32'h402, 2);
    check("clear2_status", 64'(bus.GPIO_out), 64'h0602_0000);

    set_data(16'd0, 1'b1);
    hold(32'h2, 1);
    hold(32'hA, 2);
    check("stop_status", 64'(bus.GPIO_out), 64'h0705_0000);
    check("stop_wen", 64'(bus.WRITE_EN_out), 64'd0);
    hold(32'h00A5_0102, 2);
    check("adc_div", 64'(bus.ADC_clk_div), 64'h5);
    check("mcs_div", 64'(bus.MCS_clk_div), 64'hA);
    hold(32'h0ABC_0202, 2);
    check("shape_conf", 64'(bus.shape_conf), 64'hABC);
    check("shape_status", 64'(bus.GPIO_out), 64'h0905_0000);

    hold(32'h2, 1);
    for (int i = 0; i < 256; i++) begin
      step(32'h202);
      step(32'h2);
    end
    check("seq_wrap_status", 64'(bus.GPIO_out), 64'h0905_0000);
    hold(32'h0, 2);
    check("gpio_data_mux", 64'(bus.GPIO_out), 64'hDEAD_BEEF);

    hold(32'h2, 1);
    hold(32'h3, 3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(negedge clk);
    check("async_rst_status", 64'(bus.GPIO_out), 64'h0001_0000);
    check("async_rst_wen", 64'(bus.WRITE_EN_out), 64'd0);
    check("async_rst_out", 64'(bus._RESET_out), 64'd1);
    hold(32'h3, 2);
    @(posedge clk);
    #2 rst_n = 1'b1;
    hold(32'h3, 4);
    check("held_bit_no_fire", 64'(bus.GPIO_out), 64'h0001_0000);
    hold(32'h2, 1);
    hold(32'h3, 2);
    check("restart_status", 64'(bus.GPIO_out), 64'h0103_0000);
    check("restart_wen", 64'(bus.WRITE_EN_out), 64'd1);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
